// File: rtl/sfp_vec3_dot_seq.sv
// Sequential signed fixed-point vec3 dot product: one shared multiplier, three MAC cycles,
// valid/ready on both sides, floor-truncated and saturated/wrapped OIW.OQW result.
module sfp_vec3_dot_seq #(
  parameter int IW   = 4,
  parameter int QW   = 12,
  parameter int OIW  = 8,
  parameter int OQW  = 12,
  parameter bit CLIP = 1'b1,
  localparam int W   = IW + QW,
  localparam int OW  = OIW + OQW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  a_x,
  input  logic [W-1:0]  a_y,
  input  logic [W-1:0]  a_z,
  input  logic [W-1:0]  b_x,
  input  logic [W-1:0]  b_y,
  input  logic [W-1:0]  b_z,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_data,
  output logic          clipping,
  output logic [1:0]    dbg_state
);

  localparam int PW = 2 * W;
  localparam int AW = 2 * W + 2;
  localparam int SH = 2 * QW - OQW;
  localparam int XW = ((AW > OW) ? AW : OW) + 1;
  localparam logic signed [XW-1:0] MAX_V = {{(XW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [XW-1:0] MIN_V = {{(XW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, DONE = 2'd2} state_t;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // Once out_valid rises, out_data/clipping hold until that transfer.

  state_t               state;
  logic [1:0]           idx;
  logic signed [W-1:0]  ra_x, ra_y, ra_z, rb_x, rb_y, rb_z;
  logic signed [AW-1:0] acc;
  logic signed [W-1:0]  op_a, op_b;
  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] acc_next;
  logic signed [XW-1:0] shifted;
  logic                 over, under, fits;
  logic [OW-1:0]        res_data;
  logic                 accept;

  assign in_ready  = rst_n && ((state == IDLE) || ((state == DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign dbg_state = state;

  always_comb begin
    op_a = ra_x;
    op_b = rb_x;
    case (idx)
      2'd1: begin op_a = ra_y; op_b = rb_y; end
      2'd2: begin op_a = ra_z; op_b = rb_z; end
      default: ;
    endcase
  end

  assign prod     = PW'(op_a) * PW'(op_b);
  assign acc_next = acc + AW'(prod);

  // Arithmetic shift of the sign-extended sum is a floor toward -inf on dropped LSBs.
  assign shifted = XW'(acc_next) >>> SH;
  assign over    = shifted > MAX_V;
  assign under   = shifted < MIN_V;
  assign fits    = !over && !under;

  always_comb begin
    res_data = shifted[OW-1:0];
    if (!fits && CLIP)
      res_data = over ? MAX_V[OW-1:0] : MIN_V[OW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= 2'd0;
      acc       <= '0;
      ra_x      <= '0;
      ra_y      <= '0;
      ra_z      <= '0;
      rb_x      <= '0;
      rb_y      <= '0;
      rb_z      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      clipping  <= 1'b0;
    end else begin
      if (accept) begin
        ra_x  <= a_x;
        ra_y  <= a_y;
        ra_z  <= a_z;
        rb_x  <= b_x;
        rb_y  <= b_y;
        rb_z  <= b_z;
        acc   <= '0;
        idx   <= 2'd0;
        state <= MAC;
      end
      case (state)
        IDLE: ;
        MAC: begin
          acc <= acc_next;
          if (idx == 2'd2) begin
            idx       <= 2'd0;
            state     <= DONE;
            out_valid <= 1'b1;
            out_data  <= res_data;
            clipping  <= !fits;
          end else begin
            idx <= idx + 2'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (!in_valid) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sfp_vec3_dot_seq.sv
// Bench for sfp_vec3_dot_seq: saturating and wrapping instances share stimulus; expected
// results are queued at acceptance and checked by an independent output monitor.
module tb_sfp_vec3_dot_seq;

  localparam int W  = 16;
  localparam int OW = 20;
  localparam int EW = 2 * OW + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  a_x = '0, a_y = '0, a_z = '0, b_x = '0, b_y = '0, b_z = '0;
  logic          in_ready, out_valid, clipping;
  logic [OW-1:0] out_data;
  logic [1:0]    dbg_state;
  logic          w_in_ready, w_out_valid, w_clipping;
  logic [OW-1:0] w_out_data;
  logic [1:0]    w_dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [EW-1:0] exp_q[$];
  int            acc_q[$];

  sfp_vec3_dot_seq #(.IW(4), .QW(12), .OIW(8), .OQW(12), .CLIP(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_x(a_x), .a_y(a_y), .a_z(a_z), .b_x(b_x), .b_y(b_y), .b_z(b_z),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .clipping(clipping), .dbg_state(dbg_state));

  sfp_vec3_dot_seq #(.IW(4), .QW(12), .OIW(8), .OQW(12), .CLIP(1'b0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
    .a_x(a_x), .a_y(a_y), .a_z(a_z), .b_x(b_x), .b_y(b_y), .b_z(b_z),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_data(w_out_data),
    .clipping(w_clipping), .dbg_state(w_dbg_state));

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [EW-1:0] model(input logic [W-1:0] ax, ay, az, bx, by, bz);
    longint s, f, sx;
    logic [OW-1:0] cd, wd;
    logic cf, wf;
    s = longint'($signed(ax)) * longint'($signed(bx)) + longint'($signed(ay)) * longint'($signed(by))
      + longint'($signed(az)) * longint'($signed(bz));
    f = s >>> 12;
    wd = f[OW-1:0];
    sx = longint'($signed(wd));
    wf = (sx != f);
    if (f > 524287) begin cd = 20'h7FFFF; cf = 1'b1; end
    else if (f < -524288) begin cd = 20'h80000; cf = 1'b1; end
    else begin cd = wd; cf = 1'b0; end
    return {cd, cf, wd, wf};
  endfunction

  // driver: present operands, wait for acceptance, queue the expected result
  task automatic issue(input logic [W-1:0] ax, ay, az, bx, by, bz,
                       input logic [EW-1:0] e, output int acc_cyc);
    bit ok = 1'b0;
    a_x = ax; a_y = ay; a_z = az; b_x = bx; b_y = by; b_z = bz;
    in_valid = 1'b1;
    acc_cyc = -1;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        acc_cyc = cyc;
        exp_q.push_back(e);
        acc_q.push_back(cyc);
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 expected acceptance within 60 cycles");
    end
    @(posedge clk); #1;
  endtask

  task automatic settle();
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
  endtask

  // monitor / scoreboard
  initial begin
    logic [EW-1:0] e;
    logic [OW-1:0] hold_d, hold_wd;
    logic hold_c, hold_wc;
    bit fresh = 1'b1;
    int ac;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        fresh = 1'b1;
      end else if (out_valid) begin
        if (fresh) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got out_data=%0h expected no result", out_data);
          end else begin
            e  = exp_q.pop_front();
            ac = acc_q.pop_front();
            check("clip_data", 32'(out_data), 32'(e[EW-1 -: OW]));
            check("clip_flag", 32'(clipping), 32'(e[OW+1]));
            check("wrap_valid", 32'(w_out_valid), 32'd1);
            check("wrap_data", 32'(w_out_data), 32'(e[OW:1]));
            check("wrap_flag", 32'(w_clipping), 32'(e[0]));
            check("latency", 32'(cyc - ac), 32'd4);
          end
          hold_d = out_data; hold_c = clipping; hold_wd = w_out_data; hold_wc = w_clipping;
          fresh = 1'b0;
        end else begin
          check("hold_data", 32'(out_data), 32'(hold_d));
          check("hold_flag", 32'(clipping), 32'(hold_c));
          check("hold_wrap_data", 32'(w_out_data), 32'(hold_wd));
          check("hold_wrap_flag", 32'(w_clipping), 32'(hold_wc));
        end
        if (out_ready) fresh = 1'b1;
      end
    end
  end

  initial begin
    #300000;
    errors++;
    $display("FAIL watchdog: got no completion expected finish before 300us");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // stimulus
  initial begin
    int t, prev;
    logic [W-1:0] r[6];

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_clipping", 32'(clipping), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("idle_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;

    // basic, sign, floor, and saturation/wrap vectors
    out_ready = 1'b1;
    issue(16'h1000, 16'h2000, 16'h3000, 16'h4000, 16'h5000, 16'h6000,
          {20'h20000, 1'b0, 20'h20000, 1'b0}, t);
    settle();
    issue(16'hF000, 16'h0000, 16'h0000, 16'h0800, 16'h0000, 16'h0000,
          {20'hFF800, 1'b0, 20'hFF800, 1'b0}, t);
    settle();
    issue(16'h0001, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h0000,
          {20'h00000, 1'b0, 20'h00000, 1'b0}, t);
    settle();
    issue(16'hFFFF, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h0000,
          {20'hFFFFF, 1'b0, 20'hFFFFF, 1'b0}, t);
    settle();
    issue(16'h7000, 16'h7000, 16'h7000, 16'h7000, 16'h7000, 16'h7000,
          {20'h7FFFF, 1'b1, 20'h93000, 1'b1}, t);
    settle();
    issue(16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000,
          {20'h7FFFF, 1'b1, 20'hC0000, 1'b1}, t);
    settle();
    issue(16'h8000, 16'h8000, 16'h8000, 16'h7000, 16'h7000, 16'h7000,
          {20'h80000, 1'b1, 20'h58000, 1'b1}, t);
    settle();

    // backpressure: result held, new operands refused until out_ready rises
    out_ready = 1'b0;
    issue(16'h1000, 16'h1000, 16'h1000, 16'h2000, 16'h2000, 16'h2000,
          {20'h06000, 1'b0, 20'h06000, 1'b0}, t);
    in_valid = 1'b0;
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    a_x = 16'h0400; a_y = 16'hE000; a_z = 16'h1800;
    b_x = 16'h4000; b_y = 16'h0C00; b_z = 16'hE000;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    issue(16'h0400, 16'hE000, 16'h1800, 16'h4000, 16'h0C00, 16'hE000,
          {20'hFC800, 1'b0, 20'hFC800, 1'b0}, t);
    settle();

    // streaming: one accept every 4 clocks while both sides stay ready
    prev = -1;
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 6; j++) r[j] = W'($urandom_range(0, 65535));
      issue(r[0], r[1], r[2], r[3], r[4], r[5], model(r[0], r[1], r[2], r[3], r[4], r[5]), t);
      if (k > 0) check("stream_interval", 32'(t - prev), 32'd4);
      prev = t;
    end
    settle();

    // reset mid-MAC discards the in-flight op
    issue(16'h1000, 16'h2000, 16'h3000, 16'h4000, 16'h5000, 16'h6000,
          {20'h20000, 1'b0, 20'h20000, 1'b0}, t);
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    exp_q.delete();
    acc_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("no_stale_valid", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;
    issue(16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'hE000, 16'h0800,
          {20'hFF800, 1'b0, 20'hFF800, 1'b0}, t);
    settle();

    for (int i = 0; i < 40 && exp_q.size() > 0; i++) @(negedge clk);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
